uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, number of s_tick periods sampled for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 s_tick  input  1  one-clk strobe at 16x baud, from the baud rate generator.
REQ-007 dout  output  DBIT  last received data word, LSB received first.
REQ-008 rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-009 frame_err  output  1  stop-bit status of the last completed frame; 1 = stop bit sampled low.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value rx_s (2 clk latency).
REQ-011 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-012 Internal registers SHALL be a 4-bit tick counter s, a counter n of width clog2(DBIT), and a DBIT-bit shift register b.
REQ-013 IDLE: when rx_s==0, the FSM SHALL go to START and clear s; the check SHALL NOT depend on s_tick.
REQ-014 START: on each s_tick with s<7, s SHALL increment.
REQ-015 START: on the s_tick with s==7 (mid start bit), rx_s==0 SHALL go to DATA with s=0 and n=0; rx_s==1 SHALL go to IDLE as a glitch, with no done pulse and no change to dout or frame_err.
REQ-016 DATA: on each s_tick with s<15, s SHALL increment.
REQ-017 DATA: on the s_tick with s==15, the FSM SHALL set s=0 and shift b right, inserting rx_s at the MSB.
REQ-018 DATA: in the same cycle as REQ-017, if n==DBIT-1 the FSM SHALL go to STOP; otherwise n SHALL increment.
REQ-019 STOP: on each s_tick with s<SB_TICK-1, s SHALL increment.
REQ-020 STOP: on the s_tick with s==SB_TICK-1, the FSM SHALL go to IDLE, pulse rx_done_tick for exactly one clk, load dout<=b, and load frame_err<=~rx_s, all in the same cycle.
REQ-021 dout and frame_err SHALL hold their values between completions; they SHALL update only per REQ-020.
REQ-022 Clk cycles without s_tick SHALL leave s, n, b and the state unchanged, except for the IDLE transition in REQ-013.
REQ-023 A frame whose stop bit is low SHALL still complete, with frame_err=1 and dout loaded.
REQ-024 After the STOP-to-IDLE transition, a low rx_s SHALL start a new frame on the next clk, so back-to-back frames are received with no gap.
REQ-025 rx_done_tick SHALL be registered, not combinational from the state.

Reset
REQ-026 Reset SHALL force state=IDLE, s=0, n=0, b=0, dout=0, rx_done_tick=0, frame_err=0, and both synchronizer flops to 1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without a done pulse; reception SHALL resume at the next falling edge after reset deasserts.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state enumeration and the constants OVERSAMPLE=16 and START_MID=7.
REQ-029 The synchronizer SHALL be a sub-module named sync_2ff, reusable for other asynchronous inputs.
REQ-030 uart_rx SHALL contain no baud counter; it SHALL rely solely on s_tick.

Verification
REQ-031 With s_tick every 4 clk, send frame 0xA5 (start, bits LSB first, stop=1): dout=0xA5, rx_done_tick high exactly 1 clk, frame_err=0.
REQ-032 Send 0x3C with the stop bit driven 0: rx_done_tick pulses, dout=0x3C, frame_err=1.
REQ-033 Drive rx low for 4 s_ticks, then high: no rx_done_tick, FSM back in IDLE, dout unchanged from the previous frame.
REQ-034 Send 0x00 then 0xFF back-to-back with no idle bits between frames: two done pulses, dout=0x00 then 0xFF, frame_err=0 both times.
REQ-035 Assert reset during data bit 3 of frame 0x5A, release, then send 0x81: no pulse for the aborted frame; dout=0x00 until the 0x81 frame completes, then dout=0x81.
REQ-036 With SB_TICK=32, send 0x96: rx_done_tick occurs 32 s_ticks after the last data-bit sample, and dout=0x96.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Tick counter is 4 bits for 16x oversampling, wider only when the stop
  // period (1.5 or 2 stop bits) needs more than 16 ticks.
  function automatic int tick_cnt_width(input int sb_tick);
    return ($clog2(sb_tick) > 4) ? $clog2(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset to a chosen level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver driven by an external s_tick strobe.
// Valid/ready note: there is no back-pressure; rx_done_tick is a one-clk strobe and dout/frame_err stay valid until the next completion.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic [1:0]      o_dbg_state
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = tick_cnt_width(SB_TICK);

  localparam logic [SW-1:0] S_MID       = SW'(START_MID);
  localparam logic [SW-1:0] S_LAST_DATA = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LAST_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  logic            w_rx_s;
  rx_state_t       r_state, w_state_next;
  logic [SW-1:0]   r_s, w_s_next;
  logic [NW-1:0]   r_n, w_n_next;
  logic [DBIT-1:0] r_b, w_b_next, w_b_shift;
  logic [DBIT-1:0] r_dout, w_dout_next;
  logic            r_ferr, w_ferr_next;
  logic            r_done, w_done_next;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_dout  <= w_dout_next;
      r_ferr  <= w_ferr_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_dout_next  = r_dout;
    w_ferr_next  = r_ferr;
    w_done_next  = 1'b0;
    // LSB arrives first, so each new bit enters at the top and walks down.
    w_b_shift            = r_b >> 1;
    w_b_shift[DBIT-1]    = w_rx_s;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = ST_START;
          w_s_next     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_s == S_MID) begin
            if (!w_rx_s) begin
              w_state_next = ST_DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_s == S_LAST_DATA) begin
            w_s_next = '0;
            w_b_next = w_b_shift;
            if (r_n == N_LAST) begin
              w_state_next = ST_STOP;
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (r_s == S_LAST_STOP) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
            w_dout_next  = r_b;
            w_ferr_next  = ~w_rx_s;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign o_dbg_state  = r_state;

endmodule
